// File: rtl/pool_window_ctrl_pkg.sv
// Shared definitions for the 2x2 max-pool window controller.
// Holds the default sample width and the FSM state encoding.
package pool_window_ctrl_pkg;

  // Sample width of the conv/ReLU datapath (INTERNAL_BITS).
  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_READ  = S_READ,
    ST_DRAIN = S_DRAIN,
    ST_WRITE = S_WRITE,
    ST_FIN   = S_FIN
  } state_t;

endpackage

// File: rtl/pool_window_ctrl_if.sv
// Bus bundle between the window controller and its surroundings
// (input buffer, pooler, output buffer, frame control).
//
// Handshake rules, in one place:
//   - start is a one-cycle request, accepted only while the controller is idle;
//     busy rises the cycle after acceptance and falls the cycle after done.
//   - rd_data must hold the word at rd_addr exactly one cycle after rd_en.
//   - pool_en/pool_data form a shift strobe: each cycle pool_en is high the
//     pooler shifts pool_data in; pool_result is its combinational signed max.
//   - wr_en/wr_addr/wr_data form a single-cycle write; there is no back-pressure.
//   - state mirrors the controller FSM for debug and checkers.
interface pool_window_ctrl_if #(
  parameter int DATA_W = pool_window_ctrl_pkg::DATA_W_DEF,
  parameter int ADDR_W = 12
) ();
  import pool_window_ctrl_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              pool_en;
  logic [DATA_W-1:0] pool_data;
  logic [DATA_W-1:0] pool_result;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  state_t            state;

  // Controller side.
  modport master (
    input  start, rd_data, pool_result,
    output busy, done, rd_en, rd_addr, pool_en, pool_data,
           wr_en, wr_addr, wr_data, state
  );

  // Environment side (buffers, pooler, frame control).
  modport slave (
    output start, rd_data, pool_result,
    input  busy, done, rd_en, rd_addr, pool_en, pool_data,
           wr_en, wr_addr, wr_data, state
  );

endinterface

// File: rtl/pool_addr_gen.sv
// Window position counters for the 2x2 pooling scan.
// Ports:
//   clk, rst       clock, async active-low reset
//   advance_k      step to the next element of the current window
//   advance_win    step to the next window (row-major, stride 2)
//   rd_addr        input-buffer address of element k of the current window
//   wr_addr        output-buffer address of the current window
//   k_last         current element is the 4th of the window
//   last_win       current window is the last one of the frame
module pool_addr_gen #(
  parameter int                ADDR_W   = 12,
  parameter int                IMG_W    = 8,
  parameter int                IMG_H    = 8,
  parameter logic [ADDR_W-1:0] IN_BASE  = '0,
  parameter logic [ADDR_W-1:0] OUT_BASE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance_k,
  input  logic              advance_win,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              k_last,
  output logic              last_win
);

  localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] IMG_H_A  = ADDR_W'(IMG_H);
  localparam logic [ADDR_W-1:0] HALF_W_A = ADDR_W'(IMG_W / 2);
  localparam logic [ADDR_W-1:0] TWO      = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] FOUR     = ADDR_W'(4);

  logic [ADDR_W-1:0] r;
  logic [ADDR_W-1:0] c;
  logic [1:0]        k;
  logic              col_last;
  logic              row_last;

  // A window starting at c is the last in its row when c+2 > IMG_W-2;
  // rewritten as c+4 > IMG_W so nothing goes negative. Odd widths floor.
  assign col_last = (c + FOUR) > IMG_W_A;
  assign row_last = (r + FOUR) > IMG_H_A;
  assign last_win = col_last && row_last;
  assign k_last   = (k == 2'd3);

  // k[1] selects the lower row, k[0] the right column.
  assign rd_addr = IN_BASE
                 + (r + {{(ADDR_W-1){1'b0}}, k[1]}) * IMG_W_A
                 + c + {{(ADDR_W-1){1'b0}}, k[0]};
  assign wr_addr = OUT_BASE + (r >> 1) * HALF_W_A + (c >> 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r <= '0;
      c <= '0;
      k <= 2'd0;
    end else begin
      // k wraps to 0 by itself after the 4th element.
      if (advance_k) k <= k + 2'd1;
      if (advance_win) begin
        if (col_last) begin
          c <= '0;
          // Return to the origin after the last window so the next frame starts clean.
          r <= row_last ? '0 : r + TWO;
        end else begin
          c <= c + TWO;
        end
      end
    end
  end

endmodule

// File: rtl/pool_window_ctrl.sv
// Sequencer and result writer for the 2x2 max-pooling stage.
// Streams each window's four samples from the input buffer into the
// pooler's shift input and writes the pooler's max to the output buffer,
// six cycles per window.
// Ports:
//   clk   clock, rising edge
//   rst   async active-low reset (aborts a frame immediately, no done)
//   bus   pool_window_ctrl_if.master: start/busy/done, input buffer read,
//         pooler shift/result, output buffer write, debug state
module pool_window_ctrl #(
  parameter int                DATA_W   = pool_window_ctrl_pkg::DATA_W_DEF,
  parameter int                IMG_W    = 8,
  parameter int                IMG_H    = 8,
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] IN_BASE  = '0,
  parameter logic [ADDR_W-1:0] OUT_BASE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  pool_window_ctrl_if.master   bus
);
  import pool_window_ctrl_pkg::*;

  state_t            state;
  logic              busy_q;
  logic              done_q;
  logic              rd_en_q;
  logic              pool_en_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] rd_addr_raw;
  logic [ADDR_W-1:0] wr_addr_raw;
  logic              k_last;
  logic              last_win;

  pool_addr_gen #(
    .ADDR_W   (ADDR_W),
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .IN_BASE  (IN_BASE),
    .OUT_BASE (OUT_BASE)
  ) u_addr (
    .clk         (clk),
    .rst         (rst),
    .advance_k   (rd_en_q),
    .advance_win (wr_en_q),
    .rd_addr     (rd_addr_raw),
    .wr_addr     (wr_addr_raw),
    .k_last      (k_last),
    .last_win    (last_win)
  );

  // Strobes are registered alongside the state so each one is high
  // exactly while the FSM sits in its matching state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      pool_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
    end else begin
      // Read data arrives one cycle after rd_en, so the shift strobe lags by one.
      pool_en_q <= rd_en_q;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state   <= ST_READ;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
          end
        end
        ST_READ: begin
          if (k_last) begin
            state   <= ST_DRAIN;
            rd_en_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // The 4th sample shifts into the pooler at the end of this cycle.
          state   <= ST_WRITE;
          wr_en_q <= 1'b1;
        end
        ST_WRITE: begin
          wr_en_q <= 1'b0;
          if (last_win) begin
            state  <= ST_FIN;
            done_q <= 1'b1;
          end else begin
            state   <= ST_READ;
            rd_en_q <= 1'b1;
          end
        end
        ST_FIN: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          rd_en_q <= 1'b0;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state     = state;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.pool_en   = pool_en_q;
  assign bus.wr_en     = wr_en_q;
  // Address/data outputs read as zero whenever their strobe is low.
  assign bus.rd_addr   = rd_en_q ? rd_addr_raw : {ADDR_W{1'b0}};
  assign bus.wr_addr   = wr_en_q ? wr_addr_raw : {ADDR_W{1'b0}};
  assign bus.pool_data = pool_en_q ? bus.rd_data : {DATA_W{1'b0}};
  // The pooler's max is combinational; it is valid in WRITE because all four
  // samples shifted in by the end of DRAIN.
  assign bus.wr_data   = wr_en_q ? bus.pool_result : {DATA_W{1'b0}};

endmodule

// File: tb/tb_pool_window_ctrl.sv
// Bench for pool_window_ctrl: a 4x4 instance (OUT_BASE 0x100) and a 5x5
// instance (OUT_BASE 0), each with a synchronous-read buffer and a 4-deep
// signed-max pooler. Expected writes come from a nested-loop window model.
module tb_pool_window_ctrl;
  import pool_window_ctrl_pkg::*;

  localparam int DW = 32;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pool_window_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) b4 ();
  pool_window_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) b5 ();

  pool_window_ctrl #(.DATA_W(DW), .IMG_W(4), .IMG_H(4), .ADDR_W(AW),
                     .IN_BASE(12'h000), .OUT_BASE(12'h100))
    dut4 (.clk(clk), .rst(rst), .bus(b4));
  pool_window_ctrl #(.DATA_W(DW), .IMG_W(5), .IMG_H(5), .ADDR_W(AW),
                     .IN_BASE(12'h000), .OUT_BASE(12'h000))
    dut5 (.clk(clk), .rst(rst), .bus(b5));

  logic [1:0]         start_a = 2'b00;
  logic [1:0]         rd_en_a, pool_en_a, wr_en_a, done_a, busy_a;
  logic [1:0][AW-1:0] rd_addr_a, wr_addr_a;
  logic [1:0][DW-1:0] rd_data_a, pool_data_a, pool_result_a, wr_data_a;

  assign b4.start       = start_a[0];
  assign b5.start       = start_a[1];
  assign b4.rd_data     = rd_data_a[0];
  assign b5.rd_data     = rd_data_a[1];
  assign b4.pool_result = pool_result_a[0];
  assign b5.pool_result = pool_result_a[1];
  assign rd_en_a     = {b5.rd_en, b4.rd_en};
  assign pool_en_a   = {b5.pool_en, b4.pool_en};
  assign wr_en_a     = {b5.wr_en, b4.wr_en};
  assign done_a      = {b5.done, b4.done};
  assign busy_a      = {b5.busy, b4.busy};
  assign rd_addr_a   = {b5.rd_addr, b4.rd_addr};
  assign wr_addr_a   = {b5.wr_addr, b4.wr_addr};
  assign pool_data_a = {b5.pool_data, b4.pool_data};
  assign wr_data_a   = {b5.wr_data, b4.wr_data};

  // ---------------- environment: buffers and poolers ----------------
  logic [DW-1:0]           mem [2][64];
  logic [1:0][3:0][DW-1:0] sh;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      rd_data_a[i] <= rd_en_a[i] ? mem[i][rd_addr_a[i][5:0]] : 32'hDEAD_BEEF;
      if (pool_en_a[i]) sh[i] <= {sh[i][2:0], pool_data_a[i]};
    end
  end

  always_comb begin
    pool_result_a = '0;
    for (int i = 0; i < 2; i++) begin
      logic [DW-1:0] m;
      m = sh[i][0];
      for (int j = 1; j < 4; j++)
        if ($signed(sh[i][j]) > $signed(m)) m = sh[i][j];
      pool_result_a[i] = m;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] act_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int dim(input int i);
    return (i == 0) ? 4 : 5;
  endfunction

  function automatic logic [AW-1:0] out_base(input int i);
    return (i == 0) ? 12'h100 : 12'h000;
  endfunction

  // Reference: every full 2x2 window in row-major order, signed max.
  task automatic build_exp(input int i);
    int w, nw;
    logic [DW-1:0] v[4];
    logic [DW-1:0] mx;
    logic [AW-1:0] a;
    w  = dim(i);
    nw = w / 2;
    exp_q.delete();
    for (int wr = 0; wr < nw; wr++) begin
      for (int wc = 0; wc < nw; wc++) begin
        v[0] = mem[i][(2*wr)*w + 2*wc];
        v[1] = mem[i][(2*wr)*w + 2*wc + 1];
        v[2] = mem[i][(2*wr+1)*w + 2*wc];
        v[3] = mem[i][(2*wr+1)*w + 2*wc + 1];
        mx = v[0];
        for (int j = 1; j < 4; j++) if ($signed(v[j]) > $signed(mx)) mx = v[j];
        a = out_base(i) + AW'(wr*nw + wc);
        exp_q.push_back({a, mx});
      end
    end
  endtask

  task automatic fill(input int i, input int kind);
    for (int a = 0; a < 64; a++) begin
      if (kind == 0)      mem[i][a] = a;
      else if (kind == 1) mem[i][a] = a - 16;
      else                mem[i][a] = $urandom;
    end
  endtask

  // Runs one frame on instance i, monitoring every cycle, then scores it.
  task automatic run_frame(input int i, input bit repulse);
    int n, w, done_cyc, done_cnt, pe_cnt, row, col, lim;
    bit prev_rd;
    logic [AW-1:0] prev_addr;
    w = dim(i);
    lim = 2 * (w / 2);
    done_cyc = -1; done_cnt = 0; pe_cnt = 0; prev_rd = 1'b0; prev_addr = '0;
    build_exp(i);
    act_q.delete();
    @(negedge clk) start_a[i] = 1'b1;
    @(negedge clk) start_a[i] = 1'b0;
    n = 1;
    while (n < 200) begin
      if (repulse) start_a[i] = (n == 3 || n == 10);
      check("pool_en_timing", pool_en_a[i], prev_rd);
      if (pool_en_a[i]) begin
        check("pool_data", pool_data_a[i], mem[i][prev_addr[5:0]]);
        pe_cnt++;
      end
      if (rd_en_a[i]) begin
        row = int'(rd_addr_a[i]) / w;
        col = int'(rd_addr_a[i]) % w;
        check("rd_addr_range", (row < lim && col < lim), 1);
      end
      if (wr_en_a[i]) begin
        check("pool_en_per_write", pe_cnt, 4);
        pe_cnt = 0;
        act_q.push_back({wr_addr_a[i], wr_data_a[i]});
      end
      if (n == 1) check("busy_after_start", busy_a[i], 1);
      if (done_a[i]) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (done_cyc >= 0 && n == done_cyc + 1) check("busy_after_done", busy_a[i], 0);
      if (done_cyc >= 0 && n >= done_cyc + 4) break;
      prev_rd = rd_en_a[i];
      prev_addr = rd_addr_a[i];
      @(negedge clk);
      n++;
    end
    start_a[i] = 1'b0;
    check("done_cycle", done_cyc, 1 + 6 * (w/2) * (w/2));
    check("done_pulses", done_cnt, 1);
    check("write_count", act_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < act_q.size()) check($sformatf("write%0d", k), act_q[k], exp_q[k]);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input int i);
    check({tag, "_strobes"}, {busy_a[i], done_a[i], rd_en_a[i], pool_en_a[i], wr_en_a[i]}, 0);
    check({tag, "_rd_addr"}, rd_addr_a[i], 0);
    check({tag, "_wr_addr"}, wr_addr_a[i], 0);
    check({tag, "_wr_data"}, wr_data_a[i], 0);
    check({tag, "_pool_data"}, pool_data_a[i], 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int            frame;
    int            idx;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } vec_t;
  vec_t vecs[12];

  initial begin
    int i;
    vecs[0]  = '{0, 0, 12'h100, 32'd5};
    vecs[1]  = '{0, 1, 12'h101, 32'd7};
    vecs[2]  = '{0, 2, 12'h102, 32'd13};
    vecs[3]  = '{0, 3, 12'h103, 32'd15};
    vecs[4]  = '{1, 0, 12'h100, 32'hFFFF_FFF5};
    vecs[5]  = '{1, 1, 12'h101, 32'hFFFF_FFF7};
    vecs[6]  = '{1, 2, 12'h102, 32'hFFFF_FFFD};
    vecs[7]  = '{1, 3, 12'h103, 32'hFFFF_FFFF};
    vecs[8]  = '{2, 0, 12'h000, 32'd6};
    vecs[9]  = '{2, 1, 12'h001, 32'd8};
    vecs[10] = '{2, 2, 12'h002, 32'd16};
    vecs[11] = '{2, 3, 12'h003, 32'd18};

    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("rst4", 0);
    check_idle_outputs("rst5", 1);
    check("rst_state4", b4.state, ST_IDLE);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed frames: 0 = 4x4 ascending, 1 = 4x4 negative, 2 = 5x5 ascending
    for (int f = 0; f < 3; f++) begin
      i = (f == 2) ? 1 : 0;
      fill(i, (f == 1) ? 1 : 0);
      run_frame(i, 1'b0);
      for (int v = 0; v < 12; v++) begin
        if (vecs[v].frame == f) begin
          if (vecs[v].idx < act_q.size()) begin
            check($sformatf("vec%0d_addr", v), act_q[vecs[v].idx][AW+DW-1:DW], vecs[v].addr);
            check($sformatf("vec%0d_data", v), act_q[vecs[v].idx][DW-1:0], vecs[v].data);
          end else begin
            check($sformatf("vec%0d_missing", v), act_q.size(), vecs[v].idx + 1);
          end
        end
      end
    end

    // start re-pulsed mid-frame at cycles 3 and 10
    fill(0, 0);
    run_frame(0, 1'b1);

    // Reset at cycle 8 of a 4x4 frame, then restart
    fill(0, 0);
    @(negedge clk) start_a[0] = 1'b1;
    @(negedge clk) start_a[0] = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_outputs("abort", 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", {done_a[0], rd_en_a[0], wr_en_a[0]}, 0);
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_stays_idle", {busy_a[0], rd_en_a[0], wr_en_a[0], done_a[0]}, 0);
    end
    run_frame(0, 1'b0);

    // Randomized frames against the window model
    repeat (8) begin
      i = $urandom_range(0, 1);
      fill(i, 2);
      run_frame(i, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pool_window_ctrl.md
Name: pool_window_ctrl

Overview:
- Upstream sequencer and result writer for the 2x2 max-pooling stage.
- Scans a row-major feature map held in a synchronous-read buffer.
- For each 2x2 window, streams the four elements into the pooler's shift input (en/Data_in) in order (r,c), (r,c+1), (r+1,c), (r+1,c+1).
- One cycle after the fourth element, it captures the pooler's combinational max and writes it to the output buffer.
- Sits between the conv/ReLU output buffer and the pooled-map buffer.

Parameters:
- DATA_W, 32, sample width (matches INTERNAL_BITS).
- IMG_W, 8, input map width in samples (>=2).
- IMG_H, 8, input map height in samples (>=2).
- ADDR_W, 12, address width of both buffers.
- IN_BASE, 0, input map base address.
- OUT_BASE, 0, output map base address.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after last write.
- rd_en  out  1  input buffer read strobe.
- rd_addr  out  ADDR_W  input buffer address.
- rd_data  in  DATA_W  read data, valid exactly 1 cycle after rd_en.
- pool_en  out  1  shift enable to pooler (en).
- pool_data  out  DATA_W  sample to pooler (Data_in).
- pool_result  in  DATA_W  pooler max output (Data_out), signed.
- wr_en  out  1  output buffer write strobe.
- wr_addr  out  ADDR_W  output buffer address.
- wr_data  out  DATA_W  pooled value.

Behaviour:
- Reset (rst=0, async): FSM=IDLE, counters=0. busy, done, rd_en, pool_en and wr_en are 0; all address and data outputs are 0.
- FSM states: IDLE, READ, DRAIN, WRITE, FIN.
- IDLE:
  - start=1 -> READ; row r=0, col c=0, k=0; busy=1 from the next cycle.
- READ (4 cycles, k=0..3):
  - rd_en=1.
  - rd_addr = IN_BASE + (r+k[1])*IMG_W + c + k[0].
  - After k=3 -> DRAIN.
- pool_en is rd_en delayed one register; pool_data = rd_data (pass-through, no register).
  - The 4th sample therefore shifts into the pooler on the DRAIN cycle edge.
- DRAIN (1 cycle): pool_en=1 (4th sample) -> WRITE.
- WRITE (1 cycle):
  - wr_en=1, wr_data=pool_result.
  - wr_addr = OUT_BASE + (r/2)*(IMG_W/2) + c/2.
  - Next window: c+=2. If c+2 > IMG_W-2, then c=0 and r+=2.
  - If r+2 > IMG_H-2 as well -> FIN, else -> READ.
- FIN (1 cycle): done=1, busy=0 on the following cycle -> IDLE.
- Throughput: 6 cycles per window.
  - Frame latency from start to done = 1 + 6*(IMG_H/2)*(IMG_W/2) cycles.
- Odd IMG_W/IMG_H: the trailing column/row is never read (floor).
- start while busy: ignored, with no effect on counters.
- Pooler state: the pooler is not reset by this block. Every window fully overwrites the pooler's 4-deep shift register before WRITE, so stale contents never reach wr_data.
- Reset mid-frame: immediate abort. No further rd_en/wr_en; done is not pulsed. A new start is needed afterwards.
- Address arithmetic: done at ADDR_W, unsigned. Overflow past 2^ADDR_W is a configuration error and is not checked.

Decomposition:
- Shared package holds:
  - DATA_W default (INTERNAL_BITS).
  - FSM state encoding localparams (IDLE=0, READ=1, DRAIN=2, WRITE=3, FIN=4).
- Sub-module pool_addr_gen holds the r/c/k counters and produces rd_addr, wr_addr and the last-window flag.
  - It is driven by advance_k and advance_win strobes from the FSM.

Test Plan:
- 4x4 map, values 0..15 row-major, IN_BASE=0, OUT_BASE=0x100 -> writes 5@0x100, 7@0x101, 13@0x102, 15@0x103. done at cycle 25 after start.
- 4x4 map of all-negative values (-16..-1) -> writes -11, -9, -3, -1 (signed max); wr_data bits exact.
- 5x5 map, values 0..24 -> exactly 4 writes: 6, 8, 16, 18. Addresses 20-24 and column 4 are never on rd_addr.
- start re-pulsed at cycles 3 and 10 of a 4x4 frame -> identical output to a single start; one done pulse only.
- rst low at cycle 8 of a 4x4 frame -> all strobes 0 in the same cycle; no done. A restart then produces the full correct frame.
- Read-timing check: rd_en at cycle t implies pool_en at t+1 with pool_data equal to the buffer word at rd_addr(t). Exactly 4 pool_en pulses precede each wr_en.
